// File: rtl/seg_pkg.sv
// Shared types and constants for the segment translation path.
package seg_pkg;

  localparam int NUM_SEG_DEFAULT = 6;

  localparam logic [2:0] SEG_IDX_ES = 3'd0;
  localparam logic [2:0] SEG_IDX_CS = 3'd1;
  localparam logic [2:0] SEG_IDX_SS = 3'd2;
  localparam logic [2:0] SEG_IDX_DS = 3'd3;
  localparam logic [2:0] SEG_IDX_FS = 3'd4;
  localparam logic [2:0] SEG_IDX_GS = 3'd5;

  typedef enum logic [2:0] {
    SEG_FAULT_NONE        = 3'd0,
    SEG_FAULT_NOT_PRESENT = 3'd1,
    SEG_FAULT_LIMIT       = 3'd2,
    SEG_FAULT_WRITE_PROT  = 3'd3,
    SEG_FAULT_EXEC_ONLY   = 3'd4,
    SEG_FAULT_BAD_INDEX   = 3'd5
  } seg_fault_e;

  typedef struct packed {
    logic [31:0] base;
    logic [19:0] limit;
    logic [3:0]  seg_type;
    logic        s;
    logic [1:0]  dpl;
    logic        p;
    logic        b;
    logic        g;
  } seg_desc_t;

  // Access size code to (bytes - 1); the illegal code 2 is handled as a 4-byte access.
  function automatic logic [1:0] size_to_last(input logic [1:0] size);
    logic [1:0] last_v;
    case (size)
      2'd0:    last_v = 2'd0;
      2'd1:    last_v = 2'd1;
      default: last_v = 2'd3;
    endcase
    return last_v;
  endfunction

endpackage

// File: rtl/seg_desc_decode.sv
// Combinational unpacking of a raw 64-bit segment descriptor, including the
// granularity-scaled effective limit.
module seg_desc_decode
  import seg_pkg::*;
(
  input  logic [63:0] raw,
  output seg_desc_t   desc,
  output logic [31:0] eff_limit
);

  logic desc_unused_s;

  assign desc.base     = {raw[63:56], raw[39:16]};
  assign desc.limit    = {raw[51:48], raw[15:0]};
  assign desc.seg_type = raw[43:40];
  assign desc.s        = raw[44];
  assign desc.dpl      = raw[46:45];
  assign desc.p        = raw[47];
  assign desc.b        = raw[54];
  assign desc.g        = raw[55];

  // Page granularity scales the limit to 4 KiB units with the low 12 bits filled.
  assign eff_limit = desc.g ? {desc.limit, 12'hFFF} : {12'h000, desc.limit};

  // AVL and L bits carry no meaning for translation.
  assign desc_unused_s = ^raw[53:52];

endmodule

// File: rtl/segment_translate.sv
// Segment translation: (segment, offset) -> 32-bit linear address with
// descriptor checks, two-stage valid/ready pipeline.
// Optional feature macro: SEG_PROT_CHECK_EN (present/type/limit checks).
// Without it only the segment index is validated.
module segment_translate
  import seg_pkg::*;
#(
  parameter int NUM_SEG = NUM_SEG_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] descriptor_cache [NUM_SEG],
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_seg,
  input  logic [31:0] req_offset,
  input  logic [1:0]  req_size,
  input  logic        req_write,
  input  logic        req_fetch,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_linear,
  output logic        rsp_fault,
  output logic [2:0]  rsp_fault_code
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_SEG - 1);

  logic        s2_take_s;
  logic        req_ready_s;
  logic        accept_s;
  logic [63:0] desc_sel_s;

  logic        s1_valid_r;
  logic [2:0]  s1_seg_r;
  logic [31:0] s1_offset_r;
  logic [1:0]  s1_size_r;
  logic        s1_write_r;
  logic        s1_fetch_r;
  logic [63:0] s1_desc_r;

  seg_desc_t   desc_s;
  logic [31:0] eff_limit_s;
  logic        bad_index_s;
  seg_fault_e  fault_code_s;
  logic [31:0] linear_s;

  // The output register frees up when empty or being consumed this cycle.
  assign s2_take_s   = !rsp_valid | rsp_ready;
  assign req_ready_s = (!s1_valid_r | s2_take_s) & !flush;
  assign req_ready   = req_ready_s;
  assign accept_s    = req_valid & req_ready_s;

  // Pick the descriptor for the requested segment; out-of-range indices read as zero.
  always_comb begin
    desc_sel_s = 64'd0;
    for (int i = 0; i < NUM_SEG; i++) begin
      desc_sel_s = (req_seg == 3'(i)) ? descriptor_cache[i] : desc_sel_s;
    end
  end

  // Stage 1 occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (!s1_valid_r || s2_take_s) begin
      s1_valid_r <= req_valid;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 1 payload: request fields and a snapshot of the selected descriptor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_seg_r    <= 3'd0;
      s1_offset_r <= 32'd0;
      s1_size_r   <= 2'd0;
      s1_write_r  <= 1'b0;
      s1_fetch_r  <= 1'b0;
      s1_desc_r   <= 64'd0;
    end else if (accept_s) begin
      s1_seg_r    <= req_seg;
      s1_offset_r <= req_offset;
      s1_size_r   <= req_size;
      s1_write_r  <= req_write;
      s1_fetch_r  <= req_fetch;
      s1_desc_r   <= desc_sel_s;
    end else begin
      s1_seg_r    <= s1_seg_r;
      s1_offset_r <= s1_offset_r;
      s1_size_r   <= s1_size_r;
      s1_write_r  <= s1_write_r;
      s1_fetch_r  <= s1_fetch_r;
      s1_desc_r   <= s1_desc_r;
    end
  end

  seg_desc_decode u_decode (
    .raw       (s1_desc_r),
    .desc      (desc_s),
    .eff_limit (eff_limit_s)
  );

  assign bad_index_s = (s1_seg_r > LAST_IDX);

`ifdef SEG_PROT_CHECK_EN
  logic [32:0] last_s;
  logic        expand_down_s;
  logic [31:0] ed_upper_s;
  logic        limit_fault_s;
  logic        dpl_unused_s;

  // Last byte touched, one bit wider so a carry past 4 GiB is always a limit fault.
  assign last_s        = {1'b0, s1_offset_r} + {31'd0, size_to_last(s1_size_r)};
  assign expand_down_s = desc_s.s & !desc_s.seg_type[3] & desc_s.seg_type[2];
  assign ed_upper_s    = desc_s.b ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  assign limit_fault_s = last_s[32] |
                         (expand_down_s ? ((s1_offset_r <= eff_limit_s) | (last_s[31:0] > ed_upper_s))
                                        : (last_s[31:0] > eff_limit_s));
  assign dpl_unused_s  = ^desc_s.dpl;
`else
  logic prot_unused_s;

  assign prot_unused_s = ^{desc_s.limit, desc_s.seg_type, desc_s.s, desc_s.dpl, desc_s.p,
                           desc_s.b, desc_s.g, eff_limit_s, s1_size_r, s1_write_r, s1_fetch_r};
`endif

  // Prioritised fault classification and linear address for the stage 1 request.
  always_comb begin
    fault_code_s = SEG_FAULT_NONE;
    linear_s     = desc_s.base + s1_offset_r;
    if (bad_index_s) begin
      fault_code_s = SEG_FAULT_BAD_INDEX;
      linear_s     = 32'd0;
`ifdef SEG_PROT_CHECK_EN
    end else if (!desc_s.p || !desc_s.s) begin
      fault_code_s = SEG_FAULT_NOT_PRESENT;
    end else if (s1_write_r && (desc_s.seg_type[3] || !desc_s.seg_type[1])) begin
      fault_code_s = SEG_FAULT_WRITE_PROT;
    end else if (!s1_write_r && !s1_fetch_r && desc_s.seg_type[3] && !desc_s.seg_type[1]) begin
      fault_code_s = SEG_FAULT_EXEC_ONLY;
    end else if (limit_fault_s) begin
      fault_code_s = SEG_FAULT_LIMIT;
`endif
    end else begin
      fault_code_s = SEG_FAULT_NONE;
    end
  end

  // Stage 2 / response register; payload holds while the consumer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid      <= 1'b0;
      rsp_linear     <= 32'd0;
      rsp_fault      <= 1'b0;
      rsp_fault_code <= 3'd0;
    end else if (flush) begin
      rsp_valid      <= 1'b0;
      rsp_linear     <= rsp_linear;
      rsp_fault      <= rsp_fault;
      rsp_fault_code <= rsp_fault_code;
    end else if (s2_take_s && s1_valid_r) begin
      rsp_valid      <= 1'b1;
      rsp_linear     <= linear_s;
      rsp_fault      <= (fault_code_s != SEG_FAULT_NONE);
      rsp_fault_code <= fault_code_s;
    end else if (s2_take_s) begin
      rsp_valid      <= 1'b0;
      rsp_linear     <= rsp_linear;
      rsp_fault      <= rsp_fault;
      rsp_fault_code <= rsp_fault_code;
    end else begin
      rsp_valid      <= rsp_valid;
      rsp_linear     <= rsp_linear;
      rsp_fault      <= rsp_fault;
      rsp_fault_code <= rsp_fault_code;
    end
  end

endmodule

// File: tb/tb_segment_translate.sv
// Randomised + directed bench for segment_translate with a scoreboard fed by
// an arithmetic reference model of the translation rules.
module tb_segment_translate;

`ifdef SEG_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] lin;
    logic        fault;
    logic [2:0]  code;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] cache [6];
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_seg;
  logic [31:0] req_offset;
  logic [1:0]  req_size;
  logic        req_write;
  logic        req_fetch;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_linear;
  logic        rsp_fault;
  logic [2:0]  rsp_fault_code;

  int   checks = 0;
  int   errors = 0;
  int   resp_count = 0;
  exp_t sb[$];
  exp_t last_rsp;
  exp_t held_rsp;
  bit   hold_pending = 1'b0;
  bit   acc_flag;

  localparam logic [63:0] D = 64'h0000_9201_0000_FFFF;

  segment_translate dut (
    .clock            (clock),
    .reset            (reset),
    .descriptor_cache (cache),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_seg          (req_seg),
    .req_offset       (req_offset),
    .req_size         (req_size),
    .req_write        (req_write),
    .req_fetch        (req_fetch),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_linear       (rsp_linear),
    .rsp_fault        (rsp_fault),
    .rsp_fault_code   (rsp_fault_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: translation written directly from the descriptor-format rules.
  function automatic exp_t model(input logic [63:0] d, input int seg, input longint off,
                                 input int size, input bit wr, input bit fe);
    exp_t   r;
    longint base, lim, last, top;
    int     nbytes, code;
    bit     viol;
    base   = longint'({d[63:56], d[39:16]});
    lim    = longint'({d[51:48], d[15:0]});
    if (d[55]) lim = lim * 4096 + 4095;
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    last   = off + nbytes - 1;
    top    = d[54] ? 64'hFFFF_FFFF : 64'h0000_FFFF;
    if (d[44] && !d[43] && d[42]) viol = (off <= lim) || (last > top);
    else                          viol = (last > lim);
    if (!d[47] || !d[44])                code = 1;
    else if (wr && (d[43] || !d[41]))    code = 3;
    else if (!wr && !fe && d[43] && !d[41]) code = 4;
    else if (viol)                       code = 2;
    else                                 code = 0;
    if (!PROT) code = 0;
    r.lin = 32'(base + off);
    if (seg > 5) begin
      code  = 5;
      r.lin = 32'd0;
    end
    r.code  = 3'(code);
    r.fault = (code != 0);
    return r;
  endfunction

  // One clock: score the handshakes seen this cycle, then advance.
  task automatic step();
    exp_t e;
    #1;
    acc_flag = 1'b0;
    if (hold_pending && rsp_valid) begin
      check("stall_lin", rsp_linear, held_rsp.lin);
      check("stall_code", {29'd0, rsp_fault_code}, {29'd0, held_rsp.code});
    end
    hold_pending  = rsp_valid && !rsp_ready && !flush;
    held_rsp.lin  = rsp_linear;
    held_rsp.code = rsp_fault_code;
    if (rsp_valid && rsp_ready && !flush) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        resp_count++;
        last_rsp = {rsp_linear, rsp_fault, rsp_fault_code};
        check("rsp_linear", rsp_linear, e.lin);
        check("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
        check("rsp_code", {29'd0, rsp_fault_code}, {29'd0, e.code});
      end
    end
    if (req_valid && req_ready && !flush) begin
      acc_flag = 1'b1;
      sb.push_back(model(req_seg <= 3'd5 ? cache[req_seg] : 64'd0, int'(req_seg),
                         longint'(req_offset), int'(req_size), req_write, req_fetch));
    end
    if (flush) sb.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] seg, input logic [31:0] off, input logic [1:0] size,
                       input bit wr, input bit fe, input bit rr);
    req_valid = 1'b1; req_seg = seg; req_offset = off; req_size = size;
    req_write = wr; req_fetch = fe; rsp_ready = rr;
    for (int k = 0; k < 20; k++) begin
      step();
      if (acc_flag) break;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    for (int k = 0; k < 20 && (sb.size() != 0 || rsp_valid); k++) step();
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int n0;
    logic [63:0] d;
    logic [31:0] lim;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_seg = 3'd0; req_offset = 32'd0; req_size = 2'd0; req_write = 1'b0; req_fetch = 1'b0;
    for (int i = 0; i < 6; i++) cache[i] = 64'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_linear", rsp_linear, 32'd0);
    check("reset_fault", {31'd0, rsp_fault}, 32'd0);
    check("reset_code", {29'd0, rsp_fault_code}, 32'd0);
    reset = 1'b0;

    // Basic translation
    cache[3] = D;
    issue(3'd3, 32'h1234, 2'd3, 1'b0, 1'b0, 1'b1); drain();
    check("t1_linear", last_rsp.lin, 32'h0001_1234);
    check("t1_code", {29'd0, last_rsp.code}, 32'd0);
    // Limit edge
    issue(3'd3, 32'hFFFE, 2'd3, 1'b0, 1'b0, 1'b1); drain();
    check("t2_limit", {29'd0, last_rsp.code}, PROT ? 32'd2 : 32'd0);
    issue(3'd3, 32'hFFFC, 2'd3, 1'b0, 1'b0, 1'b1); drain();
    check("t2_inlimit", {29'd0, last_rsp.code}, 32'd0);
    // Code segment protections
    cache[1] = 64'h0000_9A01_0000_FFFF;
    issue(3'd1, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1); drain();
    check("t3_wprot", {29'd0, last_rsp.code}, PROT ? 32'd3 : 32'd0);
    cache[1] = 64'h0000_9801_0000_FFFF;
    issue(3'd1, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1); drain();
    check("t3_xonly", {29'd0, last_rsp.code}, PROT ? 32'd4 : 32'd0);
    issue(3'd1, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1); drain();
    check("t3_fetch", {29'd0, last_rsp.code}, 32'd0);
    // Expand-down data
    cache[2] = 64'h0000_9601_0000_0FFF;
    issue(3'd2, 32'h0FFF, 2'd0, 1'b0, 1'b0, 1'b1); drain();
    check("t4_ed_low", {29'd0, last_rsp.code}, PROT ? 32'd2 : 32'd0);
    issue(3'd2, 32'h1000, 2'd0, 1'b0, 1'b0, 1'b1); drain();
    check("t4_ed_ok", {29'd0, last_rsp.code}, 32'd0);
    check("t4_ed_lin", last_rsp.lin, 32'h0001_1000);
    issue(3'd2, 32'hFFFE, 2'd3, 1'b0, 1'b0, 1'b1); drain();
    check("t4_ed_top", {29'd0, last_rsp.code}, PROT ? 32'd2 : 32'd0);
    // Granular limit with 33-bit overflow, bad index
    cache[4] = 64'h008F_9200_0000_FFFF;
    issue(3'd4, 32'hFFFF_FFFD, 2'd3, 1'b0, 1'b0, 1'b1); drain();
    check("t6_ovf", {29'd0, last_rsp.code}, PROT ? 32'd2 : 32'd0);
    issue(3'd6, 32'h40, 2'd0, 1'b0, 1'b0, 1'b1); drain();
    check("t6_badidx", {29'd0, last_rsp.code}, 32'd5);
    check("t6_badlin", last_rsp.lin, 32'd0);

    // Back-to-back with a 1,0,0 ready pattern
    n0 = resp_count;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_seg = 3'd3; req_offset = 32'h100 * i; req_size = 2'd1;
      req_write = 1'b0; req_fetch = 1'b0;
      for (int k = 0; k < 20; k++) begin
        rsp_ready = ((k % 3) == 0);
        step();
        if (acc_flag) break;
      end
    end
    drain();
    check("t5_count", resp_count - n0, 32'd8);

    // Flush mid-stream: nothing in flight may come out
    for (int i = 0; i < 3; i++) issue(3'd3, 32'h20 * i, 2'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1; req_valid = 1'b1; rsp_ready = 1'b0;
    step();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    repeat (5) step();

    // Reset during a stall
    issue(3'd3, 32'h10, 2'd0, 1'b0, 1'b0, 1'b0);
    issue(3'd3, 32'h14, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !rsp_valid; k++) step();
    check("stall_valid", {31'd0, rsp_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_ready", {31'd0, req_ready}, 32'd1);
    sb.delete();
    hold_pending = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) step();

    // Randomised traffic
    for (int i = 0; i < 6; i++) cache[i] = {$urandom, $urandom} | 64'h0000_9000_0000_0000;
    for (int c = 0; c < 400; c++) begin
      if (($urandom % 16) == 0) begin
        d = {$urandom, $urandom};
        if (($urandom % 8) != 0) d[47] = 1'b1;
        if (($urandom % 8) != 0) d[44] = 1'b1;
        cache[$urandom_range(0, 5)] = d;
      end
      req_valid = (($urandom % 4) != 0);
      req_seg   = 3'($urandom_range(0, 7));
      req_size  = 2'($urandom);
      req_write = $urandom % 2;
      req_fetch = $urandom % 2;
      if (req_seg <= 3'd5 && ($urandom % 2) == 1) begin
        d   = cache[req_seg];
        lim = d[55] ? {d[51:48], d[15:0], 12'hFFF} : {12'h0, d[51:48], d[15:0]};
        req_offset = lim + 32'($urandom_range(0, 8)) - 32'd4;
      end else begin
        req_offset = $urandom;
      end
      rsp_ready = (($urandom % 4) != 0);
      flush     = (($urandom % 64) == 0);
      step();
    end
    flush = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
